// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU request arbiter: FSM states, funct3 codes and the
// operation payload handed from a requester to the ALU.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FUNCT3_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [FUNCT3_W-1:0] F3_ADD  = 3'h0;
  localparam logic [FUNCT3_W-1:0] F3_SLL  = 3'h1;
  localparam logic [FUNCT3_W-1:0] F3_SLT  = 3'h2;
  localparam logic [FUNCT3_W-1:0] F3_SLTU = 3'h3;
  localparam logic [FUNCT3_W-1:0] F3_XOR  = 3'h4;
  localparam logic [FUNCT3_W-1:0] F3_SRL  = 3'h5;
  localparam logic [FUNCT3_W-1:0] F3_OR   = 3'h6;
  localparam logic [FUNCT3_W-1:0] F3_AND  = 3'h7;

  typedef struct packed {
    logic [FUNCT3_W-1:0] funct3;
    logic [DATA_W-1:0]   data_1;
    logic [DATA_W-1:0]   data_2;
  } alu_op_t;

  // SLT is not offered by the attached ALU and is answered with an error instead.
  function automatic logic is_unsupported(input logic [FUNCT3_W-1:0] funct3);
    return funct3 == F3_SLT;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin grant; the pointer names the requester that wins a tie.
module alu_rr_arbiter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant_c
);

  logic r_ptr;

  always_comb begin
    o_grant_c = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant_c = 2'b01;
        2'b10:   o_grant_c = 2'b10;
        2'b11:   o_grant_c = r_ptr ? 2'b10 : 2'b01;
        default: o_grant_c = 2'b00;
      endcase
    end
  end

  // Hand priority to the requester that was not just served.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (|o_grant_c) begin
      r_ptr <= o_grant_c[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ALU front-end: arbitrates two requesters onto one shared ALU, one operation in
// flight, and returns a tagged response per accepted request.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2:0]          req0_funct3,
  input  logic [2:0]          req1_funct3,
  input  logic [31:0]         req0_data_1,
  input  logic [31:0]         req0_data_2,
  input  logic [31:0]         req1_data_1,
  input  logic [31:0]         req1_data_2,
  input  logic [TAG_W-1:0]    req0_tag,
  input  logic [TAG_W-1:0]    req1_tag,
  output logic                alu_enable,
  output logic [2:0]          alu_funct3,
  output logic [31:0]         alu_data_1,
  output logic [31:0]         alu_data_2,
  input  logic [31:0]         alu_data_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       w_grant;
  logic             w_arb_en;
  logic             w_accept;
  logic             w_sel;
  logic             w_rsp_hs;
  alu_op_t          w_op;
  logic [TAG_W-1:0] w_tag;

  // Grants are offered only in IDLE and never while reset is held.
  assign w_arb_en = (r_state == ST_IDLE) && reset_n;

  alu_rr_arbiter u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_en      (w_arb_en),
    .i_req     (req_valid),
    .o_grant_c (w_grant)
  );

  assign req_ready = w_grant;
  assign w_accept  = |w_grant;
  assign w_sel     = w_grant[1];
  assign w_op      = w_sel ? {req1_funct3, req1_data_1, req1_data_2}
                           : {req0_funct3, req0_data_1, req0_data_2};
  assign w_tag     = w_sel ? req1_tag : req0_tag;
  assign w_rsp_hs  = rsp_valid && rsp_ready;

  assign alu_enable = (r_state == ST_EXEC);
  assign rsp_valid  = (r_state == ST_RESP);
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = is_unsupported(w_op.funct3) ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: w_state_nxt = ST_CAPT;
      ST_CAPT: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, result capture and completion counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_funct3 <= '0;
      alu_data_1 <= '0;
      alu_data_2 <= '0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (w_accept) begin
        alu_funct3 <= w_op.funct3;
        alu_data_1 <= w_op.data_1;
        alu_data_2 <= w_op.data_2;
        rsp_id     <= w_sel;
        rsp_tag    <= w_tag;
        if (is_unsupported(w_op.funct3)) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (r_state == ST_CAPT) begin
        rsp_data <= alu_data_out;
        rsp_err  <= 1'b0;
      end
      if (w_rsp_hs) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model and a behavioural ALU.
module tb_alu_arbiter;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned CNT_W = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2:0]        req0_funct3, req1_funct3;
  logic [31:0]       req0_data_1, req0_data_2, req1_data_1, req1_data_2;
  logic [TAG_W-1:0]  req0_tag, req1_tag;
  logic              alu_enable;
  logic [2:0]        alu_funct3;
  logic [31:0]       alu_data_1, alu_data_2;
  logic [31:0]       alu_data_out = 32'h0;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [TAG_W-1:0]  rsp_tag;
  logic [31:0]       rsp_data;
  logic [CNT_W-1:0]  op_count;

  int n_checks;
  int n_errors;

  always #5 clock = ~clock;

  alu_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_funct3(req0_funct3), .req1_funct3(req1_funct3),
    .req0_data_1(req0_data_1), .req0_data_2(req0_data_2),
    .req1_data_1(req1_data_1), .req1_data_2(req1_data_2),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .alu_enable(alu_enable), .alu_funct3(alu_funct3),
    .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_data_out(alu_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a << b[4:0];
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Expected response payload: SLT answers with zero data instead of an ALU result.
  function automatic logic [31:0] exp_data(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f == 3'd2) ? 32'd0 : ref_alu(f, a, b);
  endfunction

  // External ALU: registered result one cycle after enable, noise otherwise.
  always @(posedge clock) begin
    if (alu_enable === 1'b1) alu_data_out <= ref_alu(alu_funct3, alu_data_1, alu_data_2);
    else                     alu_data_out <= $urandom;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int id, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
    if (id == 0) begin
      req0_funct3 = f; req0_data_1 = a; req0_data_2 = b; req0_tag = t;
    end else begin
      req1_funct3 = f; req1_data_1 = a; req1_data_2 = b; req1_tag = t;
    end
  endtask

  task automatic apply_reset;
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Issues one request on a single requester and records what the response looked like.
  task automatic run_op(input int id, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, output int lat, output int en_cnt,
                        output logic [66:0] en_op, output logic [TAG_W+33:0] rsp);
    int waitc;
    lat = -1; en_cnt = 0; en_op = '0; rsp = '0; waitc = 0;
    set_req(id, f, a, b, t);
    req_valid = (id == 0) ? 2'b01 : 2'b10;
    rsp_ready = 1'b1;
    @(negedge clock);
    while (req_ready[id] !== 1'b1 && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    if (waitc >= 20) return;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (alu_enable === 1'b1) begin
        en_cnt++;
        en_op = {alu_funct3, alu_data_1, alu_data_2};
      end
      if (rsp_valid === 1'b1) begin
        lat = c;
        rsp = {rsp_id, rsp_tag, rsp_data, rsp_err};
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rsp_ready = 1'b1;
    set_req(0, 3'd0, 32'd1, 32'd2, 5'd1);
    set_req(1, 3'd0, 32'd3, 32'd4, 5'd2);
    req_valid = 2'b11;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({req_ready, busy, rsp_valid, rsp_err, rsp_id, rsp_tag, rsp_data, alu_enable,
         alu_funct3, alu_data_1, alu_data_2, op_count} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: req_ready=%b busy=%b rsp_valid=%b rsp_data=%h alu_en=%b op_count=%0d, all required 0",
               req_ready, busy, rsp_valid, rsp_data, alu_enable, op_count);
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL first_grant_ready: req_ready=%b required 01", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 2'b00;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL first_grant_accept: busy=%b required 1", busy);
    end
  endtask

  task automatic test_add_basic;
    int lat, en_cnt;
    logic [66:0] en_op;
    logic [TAG_W+33:0] rsp;
    apply_reset();
    run_op(0, 3'd0, 32'd5, 32'd7, 5'd3, lat, en_cnt, en_op, rsp);
    n_checks++;
    if (lat !== 3) begin
      n_errors++; $display("FAIL add_latency: got %0d required 3", lat);
    end
    n_checks++;
    if (rsp !== {1'b0, 5'd3, 32'd12, 1'b0}) begin
      n_errors++; $display("FAIL add_response: got id/tag/data/err %h required %h", rsp, {1'b0, 5'd3, 32'd12, 1'b0});
    end
    n_checks++;
    if (en_cnt !== 1 || en_op !== {3'd0, 32'd5, 32'd7}) begin
      n_errors++; $display("FAIL add_alu_issue: enables=%0d op=%h required 1 and %h", en_cnt, en_op, {3'd0, 32'd5, 32'd7});
    end
    n_checks++;
    if (op_count !== 16'd1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL add_op_count: op_count=%0d busy=%b required 1 and 0", op_count, busy);
    end
  endtask

  task automatic test_round_robin;
    int g[4];
    int n_g, n_r;
    logic [32:0] exp_r;
    g = '{default: -1}; n_g = 0; n_r = 0;
    apply_reset();
    set_req(0, 3'd0, 32'd10, 32'd1, 5'd1);
    set_req(1, 3'd4, 32'd6, 32'd3, 5'd2);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int c = 0; c < 60 && n_r < 4; c++) begin
      @(negedge clock);
      if (req_ready !== 2'b00 && n_g < 4) begin
        g[n_g] = (req_ready === 2'b10) ? 1 : 0;
        n_g++;
      end
      if (rsp_valid === 1'b1) begin
        exp_r = (n_r % 2 == 0) ? {1'b0, 32'd11} : {1'b1, 32'd5};
        n_checks++;
        if ({rsp_id, rsp_data} !== exp_r) begin
          n_errors++; $display("FAIL rr_response%0d: id/data=%h required %h", n_r, {rsp_id, rsp_data}, exp_r);
        end
        n_r++;
      end
      @(posedge clock); #1;
      if (n_g == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    n_checks++;
    if (n_g !== 4 || n_r !== 4) begin
      n_errors++; $display("FAIL rr_count: grants=%0d responses=%0d required 4 and 4", n_g, n_r);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (g[i] !== i % 2) begin
        n_errors++; $display("FAIL rr_grant%0d: granted requester %0d required %0d", i, g[i], i % 2);
      end
    end
    n_checks++;
    if (op_count !== 16'd4) begin
      n_errors++; $display("FAIL rr_op_count: op_count=%0d required 4", op_count);
    end
  endtask

  task automatic test_slt;
    int lat, en_cnt;
    logic [66:0] en_op;
    logic [TAG_W+33:0] rsp;
    apply_reset();
    run_op(1, 3'd2, 32'd9, 32'd3, 5'd17, lat, en_cnt, en_op, rsp);
    n_checks++;
    if (lat !== 1) begin
      n_errors++; $display("FAIL slt_latency: got %0d required 1", lat);
    end
    n_checks++;
    if (rsp !== {1'b1, 5'd17, 32'd0, 1'b1}) begin
      n_errors++; $display("FAIL slt_response: got %h required %h", rsp, {1'b1, 5'd17, 32'd0, 1'b1});
    end
    n_checks++;
    if (en_cnt !== 0) begin
      n_errors++; $display("FAIL slt_no_alu: alu_enable seen %0d cycles required 0", en_cnt);
    end
  endtask

  task automatic test_stall;
    int lat;
    apply_reset();
    set_req(0, 3'd1, 32'd1, 32'd4, 5'd5);
    set_req(1, 3'd6, 32'd8, 32'd1, 5'd6);
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(negedge clock);
    @(posedge clock); #1;
    req_valid = 2'b00;
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) begin lat = c; break; end
    end
    n_checks++;
    if (lat !== 3) begin
      n_errors++; $display("FAIL stall_latency: got %0d required 3", lat);
    end
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd16 || busy !== 1'b1 || req_ready !== 2'b00) begin
        n_errors++;
        $display("FAIL stall_hold%0d: rsp_valid=%b rsp_data=%0d busy=%b req_ready=%b required 1,16,1,00",
                 i, rsp_valid, rsp_data, busy, req_ready);
      end
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0 || op_count !== 16'd1) begin
      n_errors++; $display("FAIL stall_release: busy=%b op_count=%0d required 0 and 1", busy, op_count);
    end
    // Offer both, then withdraw before the edge: nothing should be accepted.
    for (int k = 0; k < 2; k++) begin
      req_valid = 2'b11;
      @(negedge clock);
      n_checks++;
      if (req_ready !== 2'b10) begin
        n_errors++; $display("FAIL withdraw_grant%0d: req_ready=%b required 10", k, req_ready);
      end
      req_valid = 2'b00;
      @(posedge clock); #1;
      n_checks++;
      if (busy !== 1'b0 || op_count !== 16'd1) begin
        n_errors++; $display("FAIL withdraw_effect%0d: busy=%b op_count=%0d required 0 and 1", k, busy, op_count);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat, en_cnt, seen;
    logic [66:0] en_op;
    logic [TAG_W+33:0] rsp;
    apply_reset();
    set_req(0, 3'd0, 32'd100, 32'd23, 5'd9);
    req_valid = 2'b01;
    @(negedge clock);
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, busy, rsp_valid, rsp_err, rsp_id, rsp_tag, rsp_data, alu_enable,
         alu_funct3, alu_data_1, alu_data_2, op_count} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: busy=%b rsp_valid=%b rsp_tag=%0d alu_data_1=%h op_count=%0d, all required 0",
               busy, rsp_valid, rsp_tag, alu_data_1, op_count);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_errors++; $display("FAIL midreset_discard: activity on %0d cycles required 0", seen);
    end
    @(posedge clock); #1;
    run_op(0, 3'd7, 32'h0000_F0F0, 32'h0000_FF00, 5'd4, lat, en_cnt, en_op, rsp);
    n_checks++;
    if (lat !== 3 || rsp !== {1'b0, 5'd4, 32'h0000_F000, 1'b0} || op_count !== 16'd1) begin
      n_errors++; $display("FAIL midreset_next_op: lat=%0d rsp=%h op_count=%0d required 3, %h, 1",
                           lat, rsp, op_count, {1'b0, 5'd4, 32'h0000_F000, 1'b0});
    end
  endtask

  task automatic test_random;
    logic [2:0]        f[2];
    logic [31:0]       a[2], b[2];
    logic [TAG_W-1:0]  t[2];
    logic [1:0]        pat;
    logic [TAG_W+33:0] exp_rsp, hold;
    int ptr, eg, lat, k, cnt;
    apply_reset();
    ptr = 0; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < 2; r++) begin
        f[r] = 3'($urandom_range(0, 7));
        a[r] = $urandom;
        b[r] = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        t[r] = TAG_W'($urandom);
        set_req(r, f[r], a[r], b[r], t[r]);
      end
      pat = 2'($urandom_range(1, 3));
      eg = (pat == 2'b11) ? ptr : ((pat == 2'b01) ? 0 : 1);
      rsp_ready = 1'b0;
      req_valid = pat;
      @(negedge clock);
      n_checks++;
      if (req_ready !== ((eg == 0) ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL rand%0d_grant: valid=%b req_ready=%b required requester %0d", i, pat, req_ready, eg);
      end
      ptr = 1 - eg;
      @(posedge clock); #1;
      req_valid = 2'b00;
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clock);
        if (rsp_valid === 1'b1) begin lat = c; break; end
      end
      n_checks++;
      if (lat !== ((f[eg] == 3'd2) ? 1 : 3)) begin
        n_errors++; $display("FAIL rand%0d_latency: funct3=%0d got %0d", i, f[eg], lat);
      end
      exp_rsp = {1'(eg), t[eg], exp_data(f[eg], a[eg], b[eg]), (f[eg] == 3'd2)};
      hold = {rsp_id, rsp_tag, rsp_data, rsp_err};
      n_checks++;
      if (hold !== exp_rsp) begin
        n_errors++; $display("FAIL rand%0d_response: funct3=%0d got %h required %h", i, f[eg], hold, exp_rsp);
      end
      k = $urandom_range(0, 3);
      for (int s = 0; s < k; s++) begin
        @(negedge clock);
        n_checks++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_tag, rsp_data, rsp_err} !== exp_rsp) begin
          n_errors++; $display("FAIL rand%0d_stall%0d: valid=%b payload=%h required 1 and %h",
                               i, s, rsp_valid, {rsp_id, rsp_tag, rsp_data, rsp_err}, exp_rsp);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      cnt++;
      n_checks++;
      if (op_count !== CNT_W'(cnt) || busy !== 1'b0) begin
        n_errors++; $display("FAIL rand%0d_count: op_count=%0d busy=%b required %0d and 0", i, op_count, busy, cnt);
      end
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    set_req(0, 3'd0, 32'd0, 32'd0, '0);
    set_req(1, 3'd0, 32'd0, 32'd0, '0);
    test_reset();
    test_add_basic();
    test_round_robin();
    test_slt();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
